subservient_uart_loader: RTL

- Boot-time program loader upstream of the subservient core's debug Wishbone port.
- Receives a length-prefixed binary image over a UART RX line and writes it byte-by-byte into SRAM starting at address 0, using debug-port writes.
- Holds the core in debug mode until the image is complete, then releases it to run.
- Sits beside the clock generator in the FPGA top level, driving i_debug_mode and i_wb_dbg_* of the core.

---
 rtl/subservient_uart_loader.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/subservient_uart_loader.sv
// UART boot loader for the subservient core debug port.
// Receives a length-prefixed image and writes it byte-wise from address 0.
module subservient_uart_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int memsize      = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_rx,
  output logic        o_debug_mode,
  output logic [31:0] o_wb_dbg_adr,
  output logic [31:0] o_wb_dbg_dat,
  output logic [3:0]  o_wb_dbg_sel,
  output logic        o_wb_dbg_we,
  output logic        o_wb_dbg_stb,
  input  logic        i_wb_dbg_ack,
  output logic        o_done,
  output logic        o_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [16:0]   MEM     = 17'(memsize);

  // RX_BRK waits for the line to go high again after a framing error
  localparam logic [2:0] RX_IDLE  = 3'd0;
  localparam logic [2:0] RX_START = 3'd1;
  localparam logic [2:0] RX_DATA  = 3'd2;
  localparam logic [2:0] RX_STOP  = 3'd3;
  localparam logic [2:0] RX_BRK   = 3'd4;

  localparam logic [2:0] L_HDR0  = 3'd0;
  localparam logic [2:0] L_HDR1  = 3'd1;
  localparam logic [2:0] L_DATA  = 3'd2;
  localparam logic [2:0] L_WRITE = 3'd3;
  localparam logic [2:0] L_DONE  = 3'd4;

  logic          rx_meta_q, rx_meta_d;
  logic          rx_sync_q, rx_sync_d;
  logic [2:0]    rx_st_q, rx_st_d;
  logic [CW-1:0] tick_q, tick_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shf_q, shf_d;
  logic          rx_valid_q, rx_valid_d;
  logic          rx_ferr_q, rx_ferr_d;

  logic [2:0]  ld_st_q, ld_st_d;
  logic [15:0] len_q, len_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] new_len;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;
  logic        we_q, we_d;
  logic        stb_q, stb_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  // Two-flop synchroniser for the asynchronous RX line
  always_comb begin
    rx_meta_d = i_rx;
    rx_sync_d = rx_meta_q;
  end

  // UART receiver: mid-bit sampling, one-cycle valid / framing pulses
  always_comb begin
    rx_st_d    = rx_st_q;
    tick_d     = tick_q;
    bit_d      = bit_q;
    shf_d      = shf_q;
    rx_valid_d = 1'b0;
    rx_ferr_d  = 1'b0;
    unique case (rx_st_q)
      RX_IDLE: begin
        if (!rx_sync_q) begin
          rx_st_d = RX_START;
          tick_d  = '0;
        end
      end
      RX_START: begin
        if (tick_q == HALF_M1) begin
          tick_d  = '0;
          bit_d   = '0;
          rx_st_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (tick_q == FULL_M1) begin
          tick_d = '0;
          shf_d  = {rx_sync_q, shf_q[7:1]};
          if (bit_q == 3'd7) rx_st_d = RX_STOP;
          else               bit_d   = bit_q + 1'b1;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (tick_q == FULL_M1) begin
          tick_d = '0;
          if (rx_sync_q) begin
            rx_valid_d = 1'b1;
            rx_st_d    = RX_IDLE;
          end else begin
            rx_ferr_d = 1'b1;
            rx_st_d   = RX_BRK;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      RX_BRK: begin
        if (rx_sync_q) rx_st_d = RX_IDLE;
      end
      default: rx_st_d = RX_IDLE;
    endcase
  end

  // Loader: header capture, one debug write per byte, then release core
  always_comb begin
    ld_st_d = ld_st_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    stb_d   = stb_q;
    done_d  = done_q;
    err_d   = err_q | rx_ferr_q;
    new_len = {shf_q, len_q[7:0]};
    unique case (ld_st_q)
      L_HDR0: begin
        if (rx_valid_q) begin
          len_d   = {8'h00, shf_q};
          ld_st_d = L_HDR1;
        end
      end
      L_HDR1: begin
        if (rx_valid_q) begin
          len_d = new_len;
          if (new_len == 16'd0) begin
            ld_st_d = L_DONE;
            done_d  = 1'b1;
          end else begin
            ld_st_d = L_DATA;
            if ({1'b0, new_len} > MEM) begin
              err_d = 1'b1;
              len_d = MEM[15:0];
            end
          end
        end
      end
      L_DATA: begin
        if (rx_valid_q) begin
          adr_d   = {16'h0000, cnt_q};
          dat_d   = {4{shf_q}};
          sel_d   = 4'b0001 << cnt_q[1:0];
          we_d    = 1'b1;
          stb_d   = 1'b1;
          ld_st_d = L_WRITE;
        end
      end
      L_WRITE: begin
        if (rx_valid_q) err_d = 1'b1;
        if (i_wb_dbg_ack) begin
          stb_d = 1'b0;
          we_d  = 1'b0;
          cnt_d = cnt_q + 16'd1;
          if (cnt_d == len_q) begin
            ld_st_d = L_DONE;
            done_d  = 1'b1;
          end else begin
            ld_st_d = L_DATA;
          end
        end
      end
      L_DONE: ;
      default: ld_st_d = L_HDR0;
    endcase
  end

  // State registers, all cleared asynchronously
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_st_q    <= RX_IDLE;
      tick_q     <= '0;
      bit_q      <= '0;
      shf_q      <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
      ld_st_q    <= L_HDR0;
      len_q      <= '0;
      cnt_q      <= '0;
      adr_q      <= '0;
      dat_q      <= '0;
      sel_q      <= '0;
      we_q       <= 1'b0;
      stb_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rx_meta_q  <= rx_meta_d;
      rx_sync_q  <= rx_sync_d;
      rx_st_q    <= rx_st_d;
      tick_q     <= tick_d;
      bit_q      <= bit_d;
      shf_q      <= shf_d;
      rx_valid_q <= rx_valid_d;
      rx_ferr_q  <= rx_ferr_d;
      ld_st_q    <= ld_st_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      sel_q      <= sel_d;
      we_q       <= we_d;
      stb_q      <= stb_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign o_debug_mode = ~done_q;
  assign o_wb_dbg_adr = adr_q;
  assign o_wb_dbg_dat = dat_q;
  assign o_wb_dbg_sel = sel_q;
  assign o_wb_dbg_we  = we_q;
  assign o_wb_dbg_stb = stb_q;
  assign o_done       = done_q;
  assign o_err        = err_q;

endmodule
